// File: rtl/frame_dispatcher_if.sv
// Signal bundle between frame_dispatcher, its descriptor producer and the frame controller.
// The master view is the dispatcher itself. The slave view is the surrounding environment:
// the descriptor source plus the downstream controller.
interface frame_dispatcher_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Descriptor intake
  logic                  desc_valid;
  logic                  desc_ready;
  logic [ADDR_WIDTH-1:0] desc_base_addr;
  logic [15:0]           desc_frame_depth;
  logic [7:0]            desc_lane_stride;
  logic [31:0]           desc_exec_hints;
  logic                  flush;

  // Issue side towards the frame controller
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [15:0]           frame_depth;
  logic [7:0]            lane_stride;
  logic [31:0]           exec_hints;
  logic                  start_trigger;
  logic                  frame_done;

  // Status
  logic                  busy;
  logic [CW-1:0]         fifo_count;
  logic [15:0]           frames_completed;
  logic [7:0]            drop_count;
  logic                  irq;

  modport master (
    input  desc_valid,
    output desc_ready,
    input  desc_base_addr,
    input  desc_frame_depth,
    input  desc_lane_stride,
    input  desc_exec_hints,
    input  flush,
    output base_addr,
    output frame_depth,
    output lane_stride,
    output exec_hints,
    output start_trigger,
    input  frame_done,
    output busy,
    output fifo_count,
    output frames_completed,
    output drop_count,
    output irq
  );

  modport slave (
    output desc_valid,
    input  desc_ready,
    output desc_base_addr,
    output desc_frame_depth,
    output desc_lane_stride,
    output desc_exec_hints,
    output flush,
    input  base_addr,
    input  frame_depth,
    input  lane_stride,
    input  exec_hints,
    input  start_trigger,
    output frame_done,
    input  busy,
    input  fifo_count,
    input  frames_completed,
    input  drop_count,
    input  irq
  );

endinterface

// File: rtl/frame_dispatcher.sv
// Descriptor queue and issue sequencer in front of the frame controller.
// Descriptors are buffered in a small FIFO and issued one at a time: the head's fields are
// loaded into registered outputs, a one-cycle start_trigger follows, and the next issue waits
// for frame_done. Zero-depth descriptors are discarded and counted; completions are counted
// and each raises a one-cycle irq.
// FIFO_DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module frame_dispatcher #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  frame_dispatcher_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned DW = ADDR_WIDTH + 16 + 8 + 32;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  // FIFO storage and bookkeeping
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  // Head-of-queue fields
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [15:0]           head_depth;
  logic [7:0]            head_stride;
  logic [31:0]           head_hints;

  // Sequencer state and registered outputs
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] base_addr_q;
  logic [15:0]           frame_depth_q;
  logic [7:0]            lane_stride_q;
  logic [31:0]           exec_hints_q;
  logic                  start_trigger_q;
  logic                  irq_q;
  logic [15:0]           frames_completed_q;
  logic [7:0]            drop_count_q;

  logic desc_ready;
  logic push;
  logic pop;

  // Ready ignores a same-cycle pop so the handshake never depends on the sequencer.
  assign desc_ready = (count_q < CW'(FIFO_DEPTH)) && !bus.flush;
  assign push       = bus.desc_valid && desc_ready;
  // The sequencer takes the head whenever it is idle; flush wins over the pop.
  assign pop        = (state_q == StIdle) && (count_q != '0) && !bus.flush;

  assign {head_addr, head_depth, head_stride, head_hints} = mem_q[rd_ptr_q];

  // Descriptor storage; contents need no reset because count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.desc_base_addr, bus.desc_frame_depth,
                          bus.desc_lane_stride, bus.desc_exec_hints};
    end
  end

  // Pointer and occupancy update; flush clears everything queued and suppresses push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Issue sequencer with registered descriptor fields, pulses and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      base_addr_q        <= '0;
      frame_depth_q      <= '0;
      lane_stride_q      <= '0;
      exec_hints_q       <= '0;
      start_trigger_q    <= 1'b0;
      irq_q              <= 1'b0;
      frames_completed_q <= '0;
      drop_count_q       <= '0;
    end else begin
      start_trigger_q <= 1'b0;
      irq_q           <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            if (head_depth == 16'd0) begin
              // Empty frames never reach the controller; count them, saturating.
              if (drop_count_q != 8'hff) begin
                drop_count_q <= drop_count_q + 8'd1;
              end
            end else begin
              base_addr_q   <= head_addr;
              frame_depth_q <= head_depth;
              lane_stride_q <= head_stride;
              exec_hints_q  <= head_hints;
              state_q       <= StIssue;
            end
          end
        end
        StIssue: begin
          // Pulse lands the cycle after ISSUE, so fields have been stable a full cycle before.
          start_trigger_q <= 1'b1;
          state_q         <= StWait;
        end
        StWait: begin
          if (bus.frame_done) begin
            frames_completed_q <= frames_completed_q + 16'd1;
            irq_q              <= 1'b1;
            state_q            <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output wiring
  assign bus.desc_ready       = desc_ready;
  assign bus.base_addr        = base_addr_q;
  assign bus.frame_depth      = frame_depth_q;
  assign bus.lane_stride      = lane_stride_q;
  assign bus.exec_hints       = exec_hints_q;
  assign bus.start_trigger    = start_trigger_q;
  assign bus.busy             = (state_q != StIdle);
  assign bus.fifo_count       = count_q;
  assign bus.frames_completed = frames_completed_q;
  assign bus.drop_count       = drop_count_q;
  assign bus.irq              = irq_q;

endmodule

// File: tb/tb_frame_dispatcher.sv
// Bench for frame_dispatcher: directed scenarios with literal expectations, then randomized
// traffic, all compared every cycle against a queue-based reference model.
module tb_frame_dispatcher;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   depth;
    logic [7:0]    stride;
    logic [31:0]   hints;
  } desc_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  frame_dispatcher_if #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) bus ();

  frame_dispatcher #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending descriptors plus the frame in flight.
  // m_phase: 0 = nothing in flight, 1 = loaded (pulse due next cycle), 2 = awaiting done.
  desc_t       mq[$];
  desc_t       m_cur    = '0;
  int          m_phase  = 0;
  logic        m_trig   = 1'b0;
  logic        m_irq    = 1'b0;
  logic [15:0] m_done   = '0;
  logic [7:0]  m_drops  = '0;

  task automatic model_reset();
    mq.delete();
    m_cur   = '0;
    m_phase = 0;
    m_trig  = 1'b0;
    m_irq   = 1'b0;
    m_done  = '0;
    m_drops = '0;
  endtask

  task automatic model_step();
    int    old;
    bit    accept;
    desc_t d;
    old    = m_phase;
    accept = (mq.size() < DEPTH) && !bus.flush && bus.desc_valid;
    m_trig = (old == 1);
    m_irq  = (old == 2) && bus.frame_done;
    if (old == 1) m_phase = 2;
    if (old == 2 && bus.frame_done) begin
      m_done++;
      m_phase = 0;
    end
    if (bus.flush) begin
      mq.delete();
    end else begin
      if (old == 0 && mq.size() > 0) begin
        d = mq.pop_front();
        if (d.depth == 16'd0) begin
          if (m_drops != 8'd255) m_drops++;
        end else begin
          m_cur   = d;
          m_phase = 1;
        end
      end
      if (accept) begin
        mq.push_back({bus.desc_base_addr, bus.desc_frame_depth,
                      bus.desc_lane_stride, bus.desc_exec_hints});
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("desc_ready", 64'(bus.desc_ready), 64'((mq.size() < DEPTH) && !bus.flush));
    check("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
    check("busy", 64'(bus.busy), 64'(m_phase != 0));
    check("start_trigger", 64'(bus.start_trigger), 64'(m_trig));
    check("irq", 64'(bus.irq), 64'(m_irq));
    check("frames_completed", 64'(bus.frames_completed), 64'(m_done));
    check("drop_count", 64'(bus.drop_count), 64'(m_drops));
    check("base_addr", 64'(bus.base_addr), 64'(m_cur.addr));
    check("frame_depth", 64'(bus.frame_depth), 64'(m_cur.depth));
    check("lane_stride", 64'(bus.lane_stride), 64'(m_cur.stride));
    check("exec_hints", 64'(bus.exec_hints), 64'(m_cur.hints));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [15:0] dp,
                       input logic [7:0] s, input logic [31:0] h);
    bus.desc_valid       = v;
    bus.desc_base_addr   = a;
    bus.desc_frame_depth = dp;
    bus.desc_lane_stride = s;
    bus.desc_exec_hints  = h;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.start_trigger) ok = 1'b1;
    end
    if (!ok) check("start_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_done();
    tick();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
  endtask

  initial begin
    bit ok;
    drive(1'b0, '0, '0, '0, '0);
    bus.flush      = 1'b0;
    bus.frame_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_desc_ready", 64'(bus.desc_ready), 64'd1);
    check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_frames", 64'(bus.frames_completed), 64'd0);

    // Single descriptor: pulse two cycles after the push edge
    tick();
    drive(1'b1, 32'h1000, 16'd3, 8'd4, 32'h0);
    tick();
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    check("t1_count_after_push", 64'(bus.fifo_count), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("t1_loaded_no_pulse", 64'(bus.start_trigger), 64'd0);
    check("t1_base_early", 64'(bus.base_addr), 64'h1000);
    @(posedge clk);
    @(negedge clk);
    check("t1_pulse", 64'(bus.start_trigger), 64'd1);
    check("t1_base", 64'(bus.base_addr), 64'h1000);
    check("t1_depth", 64'(bus.frame_depth), 64'd3);
    check("t1_stride", 64'(bus.lane_stride), 64'd4);
    @(posedge clk);
    @(negedge clk);
    check("t1_pulse_once", 64'(bus.start_trigger), 64'd0);
    pulse_done();
    @(negedge clk);
    check("t1_irq", 64'(bus.irq), 64'd1);
    check("t1_frames", 64'(bus.frames_completed), 64'd1);
    check("t1_busy", 64'(bus.busy), 64'd0);

    // Stalled controller fills the FIFO; order preserved on release
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(1'b1, 32'h2000 + 32'(i) * 32'h100, 16'(i + 1), 8'(i), 32'(i * 3));
    end
    tick();
    drive(1'b1, 32'hdead_0000, 16'd7, 8'd1, 32'h1);
    @(negedge clk);
    check("t2_full_count", 64'(bus.fifo_count), 64'd4);
    check("t2_full_ready", 64'(bus.desc_ready), 64'd0);
    tick();
    tick();
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    check("t2_no_overfill", 64'(bus.fifo_count), 64'd4);
    check("t2_first_base", 64'(bus.base_addr), 64'h2000);
    pulse_done();
    for (int k = 1; k < 5; k++) begin
      wait_start(ok);
      check("t2_order", 64'(bus.base_addr), 64'h2000 + 64'(k) * 64'h100);
      pulse_done();
    end
    repeat (4) @(negedge clk);
    check("t2_frames", 64'(bus.frames_completed), 64'd6);

    // Zero-depth discards, then saturation
    tick();
    drive(1'b1, 32'h3000, 16'd0, 8'd1, 32'h0);
    tick();
    drive(1'b1, 32'h3100, 16'd0, 8'd1, 32'h0);
    tick();
    drive(1'b1, 32'h3200, 16'd5, 8'd2, 32'h0);
    tick();
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    check("t3_drops2", 64'(bus.drop_count), 64'd2);
    wait_start(ok);
    check("t3_depth5", 64'(bus.frame_depth), 64'd5);
    check("t3_base", 64'(bus.base_addr), 64'h3200);
    pulse_done();
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, $urandom, 16'd0, 8'($urandom), $urandom);
      tick();
    end
    drive(1'b0, '0, '0, '0, '0);
    repeat (3) tick();
    @(negedge clk);
    check("t3_drop_sat", 64'(bus.drop_count), 64'd255);
    check("t3_frames", 64'(bus.frames_completed), 64'd7);

    // Flush during WAIT with three queued and a concurrent push
    for (int i = 0; i < 4; i++) begin
      tick();
      drive(1'b1, 32'h4000 + 32'(i) * 32'h100, 16'd9, 8'd3, 32'h0);
    end
    tick();
    drive(1'b1, 32'h4f00, 16'd9, 8'd3, 32'h0);
    bus.flush = 1'b1;
    @(negedge clk);
    check("t4_queued", 64'(bus.fifo_count), 64'd3);
    check("t4_ready_flush", 64'(bus.desc_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    check("t4_flushed", 64'(bus.fifo_count), 64'd0);
    check("t4_busy", 64'(bus.busy), 64'd1);
    repeat (3) tick();
    pulse_done();
    @(negedge clk);
    check("t4_frames", 64'(bus.frames_completed), 64'd8);
    repeat (6) @(negedge clk);
    check("t4_idle", 64'(bus.busy), 64'd0);

    // Spurious done while idle, then reset mid-WAIT
    pulse_done();
    @(negedge clk);
    check("t5_no_irq", 64'(bus.irq), 64'd0);
    check("t5_frames", 64'(bus.frames_completed), 64'd8);
    tick();
    drive(1'b1, 32'h5000, 16'd2, 8'd1, 32'h5);
    tick();
    drive(1'b0, '0, '0, '0, '0);
    wait_start(ok);
    tick();
    reset = 1'b1;
    #1;
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_frames", 64'(bus.frames_completed), 64'd0);
    check("t5_rst_drops", 64'(bus.drop_count), 64'd0);
    check("t5_rst_base", 64'(bus.base_addr), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t5_no_stale", 64'(bus.busy), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset = ($urandom_range(0, 599) == 0);
      drive($urandom_range(0, 2) != 0, $urandom,
            ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)),
            8'($urandom), $urandom);
      bus.flush      = ($urandom_range(0, 39) == 0);
      bus.frame_done = ($urandom_range(0, 3) == 0);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    bus.flush      = 1'b0;
    bus.frame_done = 1'b0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
